mem_io_ctrl: RTL and testbench
==============================

# mem_io_ctrl

Memory and I/O subsystem that sits directly downstream of the SAYEH `cpu` and consumes its bus requests. It holds a word-addressed synchronous RAM with a programmable wait-state count and drives `Databus`/`MemDataready` back to the CPU under a 4-phase handshake. It also provides one registered output port written by `WriteIO` and a synchronized input port returned on `IO_datain`.

## Interface
- `ADDR_BITS`, 10: RAM depth is 2^ADDR_BITS 16-bit words.
- `WAIT_STATES`, 2: extra cycles between request sample and ready. Legal range 0..15.

- `clk`  in  1  single clock; all logic on the rising edge.
- `ExternalReset`  in  1  synchronous, active-low reset.
- `ReadMem`  in  1  memory read request (level; held until ready).
- `WriteMem`  in  1  memory write request (level; held until ready).
- `ReadIO`  in  1  I/O read strobe (informational; `IO_datain` is always valid).
- `WriteIO`  in  1  I/O write strobe.
- `Addressbus`  in  16  word address.
- `aluout`  in  16  write data for memory and I/O writes.
- `ext_in`  in  16  asynchronous external input pins.
- `Databus`  out  16  read data to CPU.
- `MemDataready`  out  1  handshake acknowledge.
- `IO_datain`  out  16  synchronized `ext_in`.
- `ext_out`  out  16  output port register.
- `err`  out  1  sticky conflict flag.

## Operation
- Address decode: RAM index = `Addressbus[ADDR_BITS-1:0]`. Upper bits are ignored, so aliasing/wrap-around is intentional.
- FSM states and transitions:
  - IDLE: if `ReadMem|WriteMem` is high, latch address, `aluout` and op; go to WAIT (`cnt`=WAIT_STATES) or, if WAIT_STATES=0, go directly to ACK.
  - WAIT: decrement `cnt`. When `cnt`=1, go to ACK. If both requests are low, abort to IDLE.
  - ACK: perform the access; set `MemDataready`=1; go to HOLD.
  - HOLD: keep `MemDataready`=1 while any request is high. When both are low, clear `MemDataready` and go to IDLE.
- Read: `Databus` <= RAM[addr] at the edge entering HOLD. At all other times `Databus` holds its last value.
- Write: RAM[addr] <= latched data at that same edge. Data and address are taken from the IDLE latch, not re-sampled.
- Conflict (`ReadMem` and `WriteMem` both high when sampled in IDLE):
  - No RAM write; `Databus` unchanged.
  - Handshake completes normally.
  - `err` is set and stays high until reset.
- Abort in WAIT: no RAM change, `MemDataready` never rises.
- Address or data changes after the request is sampled are ignored.
- I/O path is independent of the FSM and may coincide with memory traffic:
  - `WriteIO` high at an edge: `ext_out` <= `aluout`.
  - `IO_datain` is a 2-flop synchronized copy of `ext_in`.
- Reset (any state, including mid-transaction):
  - FSM goes to IDLE; `cnt`=0.
  - `MemDataready`=0, `Databus`=0, `ext_out`=0, `IO_datain`=0, both sync flops = 0, `err`=0.
  - RAM contents are not cleared.
  - An in-flight write is dropped.

## Timing
- Request first high at edge E0: `MemDataready` is high after edge E0+WAIT_STATES+1, and read data is valid in that same cycle.
  - WAIT_STATES=0 gives 1-cycle latency.
- `MemDataready` drops after the first edge at which both requests are sampled low in HOLD. A new request is accepted no earlier than the following edge (IDLE).
- A request re-asserted while `MemDataready` is still high is treated as a continuation of the current transaction, not a new one.
- `ext_out` latency: 1 edge. `ext_in` to `IO_datain` latency: 2 edges.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, then write 0xBEEF to address 0x0005 (WAIT_STATES=2, WriteMem held) -> `MemDataready` rises exactly 3 edges after request sample. Subsequent read of 0x0005 returns 0xBEEF on `Databus` with the same latency.
- Alias: write 0x1234 to 0x0403 with ADDR_BITS=10, then read 0x0003 -> 0x1234.
- Abort: assert WriteMem for 0x0007/0xAAAA, drop it after 1 cycle in WAIT -> no `MemDataready`; read of 0x0007 returns its prior value.
- Conflict: ReadMem and WriteMem high together -> handshake completes, `err`=1 and stays high, RAM and `Databus` unchanged. Reset clears `err`.
- I/O: WriteIO with `aluout`=0x00FF -> `ext_out`=0x00FF next cycle. `ext_in`=0x5A5A -> `IO_datain`=0x5A5A two edges later, including during a concurrent memory read.
- Reset mid-WAIT of a write of 0xDEAD to 0x0010 -> all outputs 0 on the next edge, FSM in IDLE, RAM[0x0010] keeps its old value, and the next request completes normally.

Source files
------------

// File: rtl/mem_io_ctrl_if.sv
// CPU-side bus between the SAYEH cpu and mem_io_ctrl.
// The cpu drives the requests, the address and aluout; the controller returns data and the handshake.
interface mem_io_ctrl_if;
  logic        ReadMem;
  logic        WriteMem;
  logic        ReadIO;
  logic        WriteIO;
  logic [15:0] Addressbus;
  logic [15:0] aluout;
  logic [15:0] Databus;
  logic        MemDataready;
  logic [15:0] IO_datain;

  modport master (
    output ReadMem, WriteMem, ReadIO, WriteIO, Addressbus, aluout,
    input  Databus, MemDataready, IO_datain
  );

  modport slave (
    input  ReadMem, WriteMem, ReadIO, WriteIO, Addressbus, aluout,
    output Databus, MemDataready, IO_datain
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// Word-addressed RAM with programmable wait states behind a 4-phase ready handshake,
// plus one registered output port and a 2-flop synchronized input port.
module mem_io_ctrl #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                ExternalReset,
  mem_io_ctrl_if.slave        bus,
  input  logic [15:0]         ext_in,
  output logic [15:0]         ext_out,
  output logic                err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Request captured in IDLE; later bus changes do not affect the access.
  typedef struct packed {
    logic                 wr;
    logic                 conflict;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    data;
  } req_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  req_t               req_q;
  logic               req_any;
  logic               req_take_c;
  logic               mem_we_c;
  logic               rd_load_c;
  logic               rdy_d;
  logic [DATA_W-1:0]  sync1_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  // ReadIO is informational and the upper address bits alias by design.
  logic unused_ok;
  assign unused_ok = ^{bus.ReadIO, bus.Addressbus[15:ADDR_BITS]};

  assign req_any = bus.ReadMem | bus.WriteMem;

  // State register
  always_ff @(posedge clk) begin
    if (!ExternalReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an abort in WAIT takes priority over the final count
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_any) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!req_any) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / control decode; ready is high exactly while the FSM sits in HOLD
  always_comb begin
    req_take_c = 1'b0;
    mem_we_c   = 1'b0;
    rd_load_c  = 1'b0;
    cnt_d      = cnt_q;
    rdy_d      = (state_d == ST_HOLD);
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          req_take_c = 1'b1;
          cnt_d      = CNT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_ACK: begin
        mem_we_c  = req_q.wr & ~req_q.conflict;
        rd_load_c = ~req_q.wr & ~req_q.conflict;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Request latch
  always_ff @(posedge clk) begin
    if (!ExternalReset) begin
      req_q <= '0;
    end else if (req_take_c) begin
      req_q.wr       <= bus.WriteMem & ~bus.ReadMem;
      req_q.conflict <= bus.WriteMem & bus.ReadMem;
      req_q.addr     <= bus.Addressbus[ADDR_BITS-1:0];
      req_q.data     <= bus.aluout;
    end
  end

  // Registered handshake, read data and sticky conflict flag
  always_ff @(posedge clk) begin
    if (!ExternalReset) begin
      cnt_q            <= '0;
      bus.MemDataready <= 1'b0;
      bus.Databus      <= '0;
      err              <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      bus.MemDataready <= rdy_d;
      if (rd_load_c) begin
        bus.Databus <= mem[req_q.addr];
      end
      if (req_take_c && bus.ReadMem && bus.WriteMem) begin
        err <= 1'b1;
      end
    end
  end

  // RAM storage is never cleared; a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (mem_we_c && ExternalReset) begin
      mem[req_q.addr] <= req_q.data;
    end
  end

  // I/O ports, independent of the memory FSM
  always_ff @(posedge clk) begin
    if (!ExternalReset) begin
      ext_out       <= '0;
      sync1_q       <= '0;
      bus.IO_datain <= '0;
    end else begin
      if (bus.WriteIO) begin
        ext_out <= bus.aluout;
      end
      sync1_q       <= ext_in;
      bus.IO_datain <= sync1_q;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomized scoreboard bench for mem_io_ctrl against an array-based reference model.
`timescale 1ns/1ps
module tb_mem_io_ctrl;
  localparam int unsigned AB    = 10;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 1 << AB;

  logic        clk = 1'b0;
  logic        ExternalReset;
  logic [15:0] ext_in;
  logic [15:0] ext_out;
  logic        err;

  mem_io_ctrl_if bus();

  mem_io_ctrl #(.ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .ExternalReset(ExternalReset),
    .bus          (bus),
    .ext_in       (ext_in),
    .ext_out      (ext_out),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] db;
    logic        er;
  } exp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_db;
  logic        m_err;
  logic [15:0] m_s1, m_s2, m_out;
  logic        io_rand;
  logic [15:0] ext_fixed;
  logic        rdy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // External pin driver
  initial begin
    ext_in = '0;
    forever begin
      @(negedge clk);
      ext_in = io_rand ? 16'($urandom) : ext_fixed;
    end
  end

  // Reference for the I/O ports: two-stage delay on ext_in, ext_out follows aluout on WriteIO
  always @(posedge clk) begin
    if (!ExternalReset) begin
      m_s1  = '0;
      m_s2  = '0;
      m_out = '0;
    end else begin
      m_s2 = m_s1;
      m_s1 = ext_in;
      if (bus.WriteIO) m_out = bus.aluout;
    end
  end

  always @(negedge clk) begin
    check("io_datain", 32'(bus.IO_datain), 32'(m_s2));
    check("ext_out", 32'(ext_out), 32'(m_out));
  end

  // Scoreboard monitor: every rising ready must match a queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.MemDataready && !rdy_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ready @%0t: got ready=1 expected no transaction", $time);
      end else begin
        e = sb.pop_front();
        check("databus", 32'(bus.Databus), 32'(e.db));
        check("err", 32'(err), 32'(e.er));
      end
    end
    rdy_prev = bus.MemDataready;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input int extra, input logic io_wr);
    int          n;
    int unsigned idx;
    exp_t        e;
    idx = 32'(addr) % DEPTH;
    if (rd && wr)  m_err = 1'b1;
    else if (wr)   m_mem[idx] = data;
    else           m_db = m_mem[idx];
    e.db = m_db;
    e.er = m_err;
    sb.push_back(e);
    bus.ReadMem    = rd;
    bus.WriteMem   = wr;
    bus.Addressbus = addr;
    bus.aluout     = data;
    bus.WriteIO    = io_wr;
    n = 0;
    do begin
      tick();
      n++;
      bus.WriteIO    = 1'b0;
      bus.Addressbus = 16'($urandom);
      bus.aluout     = 16'($urandom);
    end while (!bus.MemDataready && n < 40);
    check("latency", 32'(n - 1), 32'(WS + 1));
    for (int i = 0; i < extra; i++) begin
      tick();
      check("ready_hold", 32'(bus.MemDataready), 32'd1);
    end
    bus.ReadMem  = 1'b0;
    bus.WriteMem = 1'b0;
    tick();
    check("ready_drop", 32'(bus.MemDataready), 32'd0);
  endtask

  // Request dropped after one cycle in WAIT; no handshake may follow
  task automatic do_abort(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
    bus.ReadMem    = rd;
    bus.WriteMem   = wr;
    bus.Addressbus = addr;
    bus.aluout     = data;
    tick();
    tick();
    bus.ReadMem  = 1'b0;
    bus.WriteMem = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ready", 32'(bus.MemDataready), 32'd0);
    end
  endtask

  initial begin
    ExternalReset  = 1'b0;
    bus.ReadMem    = 1'b0;
    bus.WriteMem   = 1'b0;
    bus.ReadIO     = 1'b0;
    bus.WriteIO    = 1'b0;
    bus.Addressbus = '0;
    bus.aluout     = '0;
    io_rand        = 1'b0;
    ext_fixed      = 16'h0000;
    m_db           = '0;
    m_err          = 1'b0;
    repeat (3) tick();
    check("rst_databus", 32'(bus.Databus), 32'd0);
    check("rst_ready", 32'(bus.MemDataready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    ExternalReset = 1'b1;
    tick();

    for (int a = 0; a < 32; a++) do_req(1'b0, 1'b1, 16'(a), 16'($urandom), 0, 1'b0);

    do_req(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0, 1'b0);
    do_req(1'b1, 1'b0, 16'h0005, 16'h0000, 1, 1'b0);
    check("read_beef", 32'(bus.Databus), 32'h0000BEEF);

    do_req(1'b0, 1'b1, 16'h0403, 16'h1234, 0, 1'b0);
    do_req(1'b1, 1'b0, 16'h0003, 16'h0000, 0, 1'b0);
    check("alias", 32'(bus.Databus), 32'h00001234);

    do_abort(1'b0, 1'b1, 16'h0007, 16'hAAAA);
    do_req(1'b1, 1'b0, 16'h0007, 16'h0000, 0, 1'b0);

    do_req(1'b1, 1'b1, 16'h0009, 16'h7777, 2, 1'b0);
    do_req(1'b1, 1'b0, 16'h0009, 16'h0000, 0, 1'b0);
    check("err_sticky", 32'(err), 32'd1);

    bus.WriteIO = 1'b1;
    bus.aluout  = 16'h00FF;
    tick();
    bus.WriteIO = 1'b0;
    check("ext_out_ff", 32'(ext_out), 32'h000000FF);
    ext_fixed = 16'h5A5A;
    do_req(1'b1, 1'b0, 16'h0011, 16'h0000, 0, 1'b0);
    check("io_5a5a", 32'(bus.IO_datain), 32'h00005A5A);

    // Reset in the middle of WAIT for a write of 0xDEAD to 0x0010
    bus.WriteMem   = 1'b1;
    bus.Addressbus = 16'h0010;
    bus.aluout     = 16'hDEAD;
    tick();
    ExternalReset = 1'b0;
    tick();
    check("rst_mid_databus", 32'(bus.Databus), 32'd0);
    check("rst_mid_ready", 32'(bus.MemDataready), 32'd0);
    check("rst_mid_ext_out", 32'(ext_out), 32'd0);
    check("rst_mid_io", 32'(bus.IO_datain), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    bus.WriteMem  = 1'b0;
    ExternalReset = 1'b1;
    m_db  = '0;
    m_err = 1'b0;
    tick();
    check("rst_sync_flop", 32'(bus.IO_datain), 32'd0);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);

    io_rand = 1'b1;
    for (int t = 0; t < 80; t++) begin
      int unsigned op;
      logic [15:0] addr;
      op   = $urandom_range(0, 19);
      addr = {6'($urandom), 10'($urandom_range(0, 31))};
      if (op < 2)       do_abort(op[0], ~op[0], addr, 16'($urandom));
      else if (op < 3)  do_req(1'b1, 1'b1, addr, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      else if (op < 11) do_req(1'b0, 1'b1, addr, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      else              do_req(1'b1, 1'b0, addr, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    repeat (4) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
